// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, canonical NOP, fault codes and
// register-index field positions within a 32-bit instruction word.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;

    function automatic logic [4:0] field_rs1(input logic [31:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [4:0] field_rs2(input logic [31:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

    function automatic logic [4:0] field_rd(input logic [31:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting for instruction memory; tc flags that the
// count has reached LIMIT. Clear has priority over enable.
module fetch_timeout_ctr #(
    parameter int LIMIT = 16,
    localparam int W = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + W'(1);
        end
    end

    assign tc = (count_q == W'(LIMIT));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time from instruction memory,
// holds it for the register-file stage and applies redirects or sticky faults.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          WAIT_TIMEOUT = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic [31:0]  imem_data_i,
    input  logic         imem_ack_i,
    input  logic         stall_i,
    input  logic         branch_taken_i,
    input  logic [31:0]  branch_target_i,
    output logic [31:0]  instr_o,
    output logic         valid_o,
    output logic [31:0]  pc_o,
    output logic [31:0]  pc4_o,
    output logic [4:0]   rs1_o,
    output logic [4:0]   rs2_o,
    output logic [4:0]   rd_o,
    output logic         fault_o,
    output logic [1:0]   fault_code_o,
    output fetch_state_e dbg_state_o
);

    // Handshakes: imem_req_o is raised in REQ/WAIT and held with a stable address until
    // imem_ack_i is seen high on a rising edge; that edge captures imem_data_i and ends
    // the request. Downstream, valid_o marks instr_o as offered; the instruction is
    // consumed on any rising edge where valid_o=1 and stall_i=0, and only then are
    // branch_taken_i/branch_target_i sampled.

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [1:0]   code_q, code_d;
    logic         cnt_clr, cnt_en, cnt_tc;

    fetch_timeout_ctr #(
        .LIMIT (WAIT_TIMEOUT)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            code_q  <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        code_d  = code_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack_i) begin
                    instr_d = imem_data_i;
                    cnt_clr = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_en  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack_i) begin
                    instr_d = imem_data_i;
                    cnt_clr = 1'b1;
                    state_d = ST_ISSUE;
                end else if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    code_d  = FAULT_TIMEOUT;
                    state_d = ST_FAULT;
                end else begin
                    cnt_en  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!stall_i) begin
                    // A misaligned redirect leaves the PC pointing at the faulting branch.
                    if (branch_taken_i && (branch_target_i[1:0] != 2'b00)) begin
                        code_d  = FAULT_MISALIGN;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = branch_taken_i ? branch_target_i : (pc_q + 32'd4);
                        state_d = ST_REQ;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    assign imem_req_o   = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign imem_addr_o  = pc_q;
    assign valid_o      = (state_q == ST_ISSUE);
    assign instr_o      = valid_o ? instr_q : NOP_INSTR;
    assign pc_o         = pc_q;
    assign pc4_o        = pc_q + 32'd4;
    assign rs1_o        = field_rs1(instr_o);
    assign rs2_o        = field_rs2(instr_o);
    assign rd_o         = field_rd(instr_o);
    assign fault_o      = (state_q == ST_FAULT);
    assign fault_code_o = code_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: handshake timing, stall, redirect,
// fault paths and PC wrap, with hand-computed expectations.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // main instance, RESET_PC = 0
    logic         rst = 1'b0;
    logic         req, valid, fault;
    logic [31:0]  addr, instr, pc, pc4;
    logic [31:0]  data = '0;
    logic         ack = 1'b0, stall = 1'b0, br = 1'b0;
    logic [31:0]  tgt = '0;
    logic [4:0]   rs1, rs2, rd;
    logic [1:0]   fcode;
    fetch_state_e st;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_TIMEOUT(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req), .imem_addr_o(addr), .imem_data_i(data), .imem_ack_i(ack),
        .stall_i(stall), .branch_taken_i(br), .branch_target_i(tgt),
        .instr_o(instr), .valid_o(valid), .pc_o(pc), .pc4_o(pc4),
        .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .fault_o(fault), .fault_code_o(fcode), .dbg_state_o(st)
    );

    // wrap instance, RESET_PC = 0xFFFFFFFC
    logic         w_rst = 1'b0;
    logic         w_req, w_valid, w_fault;
    logic [31:0]  w_addr, w_instr, w_pc, w_pc4;
    logic [31:0]  w_data = 32'h0000_0013;
    logic         w_ack = 1'b0, w_stall = 1'b0, w_br = 1'b0;
    logic [31:0]  w_tgt = '0;
    logic [4:0]   w_rs1, w_rs2, w_rd;
    logic [1:0]   w_fcode;
    fetch_state_e w_st;

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .WAIT_TIMEOUT(16)) u_wrap (
        .clk_i(clk), .rst_i(w_rst),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_data_i(w_data), .imem_ack_i(w_ack),
        .stall_i(w_stall), .branch_taken_i(w_br), .branch_target_i(w_tgt),
        .instr_o(w_instr), .valid_o(w_valid), .pc_o(w_pc), .pc4_o(w_pc4),
        .rs1_o(w_rs1), .rs2_o(w_rs2), .rd_o(w_rd),
        .fault_o(w_fault), .fault_code_o(w_fcode), .dbg_state_o(w_st)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1; ack = 1'b0; stall = 1'b0; br = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++; if (st !== ST_BOOT) begin n_fail++; $display("FAIL rst_state: got %0d exp %0d", st, ST_BOOT); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", req); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", valid); end
        n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr: got %h exp 00000013", instr); end
        n_checks++; if (pc !== 32'h0 || pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc: got %h/%h exp 0/4", pc, pc4); end
        n_checks++; if (fault !== 1'b0 || fcode !== 2'b00) begin n_fail++; $display("FAIL rst_fault: got %b/%b exp 0/00", fault, fcode); end
        n_checks++; if (rs1 !== 5'd0 || rs2 !== 5'd0 || rd !== 5'd0) begin n_fail++; $display("FAIL rst_fields: got %0d %0d %0d exp 0 0 0", rs1, rs2, rd); end
        step();
        rst = 1'b0;
        step();  // BOOT -> REQ
        n_checks++; if (req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL boot_req: got %b @%h exp 1 @00000000", req, addr); end
    endtask

    task automatic test_zero_wait();
        ack = 1'b1; data = 32'h0050_0093;
        step();
        ack = 1'b0; data = 32'hDEAD_BEEF;
        n_checks++; if (valid !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL zw_issue0: got v=%b r=%b exp v=1 r=0", valid, req); end
        n_checks++; if (instr !== 32'h0050_0093 || pc !== 32'h0) begin n_fail++; $display("FAIL zw_instr0: got %h@%h exp 00500093@0", instr, pc); end
        n_checks++; if (rd !== 5'd1 || rs1 !== 5'd0 || rs2 !== 5'd5) begin n_fail++; $display("FAIL zw_fields0: got rd=%0d rs1=%0d rs2=%0d exp 1 0 5", rd, rs1, rs2); end
        step();
        n_checks++; if (req !== 1'b1 || addr !== 32'h4 || valid !== 1'b0) begin n_fail++; $display("FAIL zw_req1: got r=%b a=%h v=%b exp 1 4 0", req, addr, valid); end
        n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL zw_nop: got %h exp 00000013", instr); end
        ack = 1'b1; data = 32'h00A0_0113;
        step();
        ack = 1'b0;
        n_checks++; if (valid !== 1'b1 || instr !== 32'h00A0_0113 || pc !== 32'h4) begin n_fail++; $display("FAIL zw_issue1: got v=%b %h@%h exp 1 00a00113@4", valid, instr, pc); end
        n_checks++; if (rd !== 5'd2 || rs1 !== 5'd0 || rs2 !== 5'd10) begin n_fail++; $display("FAIL zw_fields1: got rd=%0d rs1=%0d rs2=%0d exp 2 0 10", rd, rs1, rs2); end
        step();
        n_checks++; if (req !== 1'b1 || addr !== 32'h8) begin n_fail++; $display("FAIL zw_req2: got %b @%h exp 1 @8", req, addr); end
    endtask

    task automatic test_wait();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (req !== 1'b1 || addr !== 32'h8 || valid !== 1'b0 || st !== ST_WAIT) begin n_fail++; $display("FAIL wait_hold%0d: got r=%b a=%h v=%b s=%0d exp 1 8 0 WAIT", i, req, addr, valid, st); end
        end
        ack = 1'b1; data = 32'h0030_0193;
        step();
        ack = 1'b0;
        n_checks++; if (valid !== 1'b1 || instr !== 32'h0030_0193 || rd !== 5'd3 || pc !== 32'h8) begin n_fail++; $display("FAIL wait_issue: got v=%b %h rd=%0d pc=%h exp 1 00300193 3 8", valid, instr, rd, pc); end
    endtask

    task automatic test_stall();
        stall = 1'b1; tgt = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            br = i[0];
            step();
            n_checks++; if (valid !== 1'b1 || instr !== 32'h0030_0193 || pc !== 32'h8 || req !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b %h pc=%h r=%b exp 1 00300193 8 0", i, valid, instr, pc, req); end
        end
        stall = 1'b0; br = 1'b0;
        step();
        n_checks++; if (req !== 1'b1 || addr !== 32'hC || valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got r=%b a=%h v=%b exp 1 c 0", req, addr, valid); end
        ack = 1'b1; data = 32'h0000_0013;
        step();
        ack = 1'b0;
    endtask

    task automatic test_branch();
        br = 1'b1; tgt = 32'h0000_0100;
        step();
        br = 1'b0;
        n_checks++; if (req !== 1'b1 || addr !== 32'h100 || pc4 !== 32'h104) begin n_fail++; $display("FAIL branch_redirect: got r=%b a=%h pc4=%h exp 1 100 104", req, addr, pc4); end
        ack = 1'b1; data = 32'h0041_8213;
        step();
        ack = 1'b0;
        n_checks++; if (valid !== 1'b1 || pc !== 32'h100 || rd !== 5'd4 || rs1 !== 5'd3 || rs2 !== 5'd4) begin n_fail++; $display("FAIL branch_issue: got v=%b pc=%h rd=%0d rs1=%0d rs2=%0d exp 1 100 4 3 4", valid, pc, rd, rs1, rs2); end
    endtask

    task automatic test_misaligned();
        br = 1'b1; tgt = 32'h0000_0102;
        step();
        br = 1'b0;
        n_checks++; if (fault !== 1'b1 || fcode !== 2'b01) begin n_fail++; $display("FAIL mis_fault: got %b/%b exp 1/01", fault, fcode); end
        n_checks++; if (req !== 1'b0 || valid !== 1'b0 || pc !== 32'h100 || instr !== 32'h0000_0013) begin n_fail++; $display("FAIL mis_outputs: got r=%b v=%b pc=%h i=%h exp 0 0 100 00000013", req, valid, pc, instr); end
        for (int i = 0; i < 5; i++) begin
            ack = i[0]; br = ~i[0]; tgt = 32'h0000_0200;
            step();
            n_checks++; if (req !== 1'b0 || fault !== 1'b1 || fcode !== 2'b01 || pc !== 32'h100) begin n_fail++; $display("FAIL mis_sticky%0d: got r=%b f=%b c=%b pc=%h exp 0 1 01 100", i, req, fault, fcode, pc); end
        end
        ack = 1'b0; br = 1'b0;
        do_reset();
        n_checks++; if (fault !== 1'b0 || fcode !== 2'b00 || pc !== 32'h0 || st !== ST_BOOT) begin n_fail++; $display("FAIL mis_reset: got f=%b c=%b pc=%h s=%0d exp 0 00 0 BOOT", fault, fcode, pc, st); end
        step();
        n_checks++; if (req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL mis_restart: got %b @%h exp 1 @0", req, addr); end
    endtask

    task automatic test_timeout();
        ack = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            n_checks++; if (req !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got r=%b f=%b exp 1 0", i, req, fault); end
        end
        step();
        n_checks++; if (fault !== 1'b1 || fcode !== 2'b10 || req !== 1'b0) begin n_fail++; $display("FAIL to_fault: got f=%b c=%b r=%b exp 1 10 0", fault, fcode, req); end
        ack = 1'b1; data = 32'h0050_0093;
        step();
        ack = 1'b0;
        n_checks++; if (valid !== 1'b0 || fcode !== 2'b10) begin n_fail++; $display("FAIL to_late_ack: got v=%b c=%b exp 0 10", valid, fcode); end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        step();
        ack = 1'b0;
        step();  // WAIT with req high
        #1 rst = 1'b1;
        #1;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b exp 0", req); end
        ack = 1'b1;
        step();
        rst = 1'b0;
        step();  // BOOT -> REQ; ack held high is a late ack and must not issue
        n_checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL rst_late_ack: got v=%b r=%b a=%h exp 0 1 0", valid, req, addr); end
        ack = 1'b0;
    endtask

    task automatic test_wrap();
        w_rst = 1'b1;
        #2;
        n_checks++; if (w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_reset: got %h/%h exp fffffffc/0", w_pc, w_pc4); end
        step();
        w_rst = 1'b0;
        step();
        n_checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0: got %b @%h exp 1 @fffffffc", w_req, w_addr); end
        w_ack = 1'b1;
        step();
        w_ack = 1'b0;
        n_checks++; if (w_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_issue: got %b exp 1", w_valid); end
        step();
        n_checks++; if (w_req !== 1'b1 || w_addr !== 32'h0 || w_pc4 !== 32'h4) begin n_fail++; $display("FAIL wrap_req1: got %b @%h pc4=%h exp 1 @0 4", w_req, w_addr, w_pc4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_wait();
        test_stall();
        test_branch();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
